// File: rtl/maze_probe.sv
// Maze-side responder: probes the four tiles around a sprite position through a
// synchronous tile memory and publishes all four passability codes at once.
module maze_probe #(
  parameter int COORD_W    = 9,
  parameter int TILE_BITS  = 3,
  parameter int MAP_W_BITS = 5,
  parameter int MAP_H_BITS = 5,
  parameter int DATA_W     = 3
) (
  input  logic                             clk_50mhz,
  input  logic                             rst_n,
  input  logic [COORD_W-1:0]               x,
  input  logic [COORD_W-1:0]               y,
  input  logic                             refresh,
  output logic [MAP_W_BITS+MAP_H_BITS-1:0] mem_addr,
  output logic                             mem_rd,
  input  logic [DATA_W-1:0]                mem_data,
  output logic [DATA_W-1:0]                flag_L,
  output logic [DATA_W-1:0]                flag_U,
  output logic [DATA_W-1:0]                flag_R,
  output logic [DATA_W-1:0]                flag_D,
  output logic                             flags_valid,
  output logic                             busy
);

  localparam int PW = COORD_W + 1;
  localparam int TW = PW - TILE_BITS;
  localparam int AW = MAP_W_BITS + MAP_H_BITS;
  localparam logic [PW-1:0] ONE_PIX  = PW'(1);
  localparam logic [PW-1:0] TILE_PIX = PW'(1 << TILE_BITS);

  typedef enum logic [2:0] {IDLE, ISS_L, ISS_U, ISS_R, ISS_D, LAST} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  px_q, py_q;
  logic                stale_q;
  logic                start;
  logic [AW-1:0]       addr_q;
  logic [DATA_W-1:0]   sh_l, sh_u, sh_r;

  function automatic logic [TW-1:0] to_tile(input logic [PW-1:0] p);
    return TW'(p >> TILE_BITS);
  endfunction

  function automatic logic in_w(input logic [TW-1:0] t);
    return (t >> MAP_W_BITS) == '0;
  endfunction

  function automatic logic in_h(input logic [TW-1:0] t);
    return (t >> MAP_H_BITS) == '0;
  endfunction

  // Neighbour geometry is computed one bit wider so px+T cannot wrap into the map.
  logic [PW-1:0] px_w, py_w;
  logic [TW-1:0] tx_c, ty_c, tx_l, ty_u, tx_r, ty_d;
  logic          x_aln, y_aln;
  logic          ok_l, ok_u, ok_r, ok_d;
  logic [AW-1:0] addr_l, addr_u, addr_r, addr_d;

  assign px_w  = {1'b0, px_q};
  assign py_w  = {1'b0, py_q};
  assign tx_c  = to_tile(px_w);
  assign ty_c  = to_tile(py_w);
  assign tx_l  = to_tile(px_w - ONE_PIX);
  assign ty_u  = to_tile(py_w - ONE_PIX);
  assign tx_r  = to_tile(px_w + TILE_PIX);
  assign ty_d  = to_tile(py_w + TILE_PIX);
  assign x_aln = (px_q[TILE_BITS-1:0] == '0);
  assign y_aln = (py_q[TILE_BITS-1:0] == '0);

  assign ok_l = y_aln && (px_q != '0) && in_w(tx_l) && in_h(ty_c);
  assign ok_u = x_aln && (py_q != '0) && in_w(tx_c) && in_h(ty_u);
  assign ok_r = y_aln && in_w(tx_r) && in_h(ty_c);
  assign ok_d = x_aln && in_w(tx_c) && in_h(ty_d);

  assign addr_l = {ty_c[MAP_H_BITS-1:0], tx_l[MAP_W_BITS-1:0]};
  assign addr_u = {ty_u[MAP_H_BITS-1:0], tx_c[MAP_W_BITS-1:0]};
  assign addr_r = {ty_c[MAP_H_BITS-1:0], tx_r[MAP_W_BITS-1:0]};
  assign addr_d = {ty_d[MAP_H_BITS-1:0], tx_c[MAP_W_BITS-1:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = addr_q;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (stale_q || refresh || (x != px_q) || (y != py_q)) begin
          state_d = ISS_L;
          start   = 1'b1;
        end
      end
      ISS_L: begin
        state_d = ISS_U;
        if (ok_l) begin
          mem_rd   = 1'b1;
          mem_addr = addr_l;
        end
      end
      ISS_U: begin
        state_d = ISS_R;
        if (ok_u) begin
          mem_rd   = 1'b1;
          mem_addr = addr_u;
        end
      end
      ISS_R: begin
        state_d = ISS_D;
        if (ok_r) begin
          mem_rd   = 1'b1;
          mem_addr = addr_r;
        end
      end
      ISS_D: begin
        state_d = LAST;
        if (ok_d) begin
          mem_rd   = 1'b1;
          mem_addr = addr_d;
        end
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      stale_q     <= 1'b1;
      busy        <= 1'b0;
      addr_q      <= '0;
      sh_l        <= '0;
      sh_u        <= '0;
      sh_r        <= '0;
      flag_L      <= '0;
      flag_U      <= '0;
      flag_R      <= '0;
      flag_D      <= '0;
      flags_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= mem_addr;
      flags_valid <= 1'b0;
      if (start) begin
        px_q    <= x;
        py_q    <= y;
        busy    <= 1'b1;
        stale_q <= 1'b0;
      end else if ((state_q != IDLE) && refresh) begin
        stale_q <= 1'b1;
      end
      // Each slot's data arrives one cycle after its issue; D is taken straight off the bus.
      case (state_q)
        ISS_U: sh_l <= ok_l ? mem_data : '0;
        ISS_R: sh_u <= ok_u ? mem_data : '0;
        ISS_D: sh_r <= ok_r ? mem_data : '0;
        LAST: begin
          flag_L      <= sh_l;
          flag_U      <= sh_u;
          flag_R      <= sh_r;
          flag_D      <= ok_d ? mem_data : '0;
          flags_valid <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_probe.sv
// Scoreboard bench for maze_probe: a tile-level model predicts flags and read
// slots per probe; a negedge monitor pairs each flags_valid pulse with a prediction.
module tb_maze_probe;

  localparam int COORD_W = 9;
  localparam int DATA_W  = 3;
  localparam int AW      = 10;

  logic               clk_50mhz = 1'b0;
  logic               rst_n;
  logic [COORD_W-1:0] x, y;
  logic               refresh;
  logic [AW-1:0]      mem_addr;
  logic               mem_rd;
  logic [DATA_W-1:0]  mem_q = '0;
  logic [DATA_W-1:0]  flag_L, flag_U, flag_R, flag_D;
  logic               flags_valid;
  logic               busy;

  always #10 clk_50mhz = ~clk_50mhz;

  maze_probe dut (
    .clk_50mhz   (clk_50mhz),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .refresh     (refresh),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_q),
    .flag_L      (flag_L),
    .flag_U      (flag_U),
    .flag_R      (flag_R),
    .flag_D      (flag_D),
    .flags_valid (flags_valid),
    .busy        (busy)
  );

  // Tile memory with one-cycle read latency.
  logic [DATA_W-1:0] mem [1024];
  always @(posedge clk_50mhz) if (mem_rd) mem_q <= mem[mem_addr];

  typedef struct packed {
    logic [3:0][2:0] fl;
    logic [3:0]      rv;
    logic [3:0][9:0] ra;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    probes_seen = 0;
  int    cur_x = 200;
  int    cur_y = 232;
  string dn[4] = '{"L", "U", "R", "D"};

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Direction d: 0=L (x-1,y), 1=U (x,y-1), 2=R (x+8,y), 3=D (x,y+8), 8-px tiles on a 32x32 map.
  function automatic exp_t model(input int px, input int py);
    exp_t e;
    int   nx, ny;
    bit   ok;
    e = '0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin ok = (py % 8 == 0) && (px > 0); nx = (px > 0) ? (px - 1) / 8 : 0; ny = py / 8; end
        1:       begin ok = (px % 8 == 0) && (py > 0); nx = px / 8; ny = (py > 0) ? (py - 1) / 8 : 0; end
        2:       begin ok = (py % 8 == 0); nx = (px + 8) / 8; ny = py / 8; end
        default: begin ok = (px % 8 == 0); nx = px / 8; ny = (py + 8) / 8; end
      endcase
      ok = ok && (nx < 32) && (ny < 32);
      if (ok) begin
        e.rv[d] = 1'b1;
        e.ra[d] = 10'(ny * 32 + nx);
        e.fl[d] = mem[ny * 32 + nx];
      end
    end
    return e;
  endfunction

  // Monitor: tracks read slots relative to the busy rise and scores each flags_valid.
  int              cyc = 0, c0 = 0, busy_cnt = 0;
  bit              prev_busy = 1'b0;
  logic [3:0]      got_rv = '0;
  logic [3:0][9:0] got_ra = '0;
  logic [3:0][2:0] prev_flags = '0;

  always @(negedge clk_50mhz) begin : mon
    exp_t            e;
    int              off;
    logic [3:0][2:0] cur_fl;
    cyc++;
    cur_fl = {flag_D, flag_R, flag_U, flag_L};
    if (!rst_n) begin
      prev_busy  = 1'b0;
      got_rv     = '0;
      busy_cnt   = 0;
      prev_flags = cur_fl;
    end else begin
      if (busy && !prev_busy) begin
        c0       = cyc;
        got_rv   = '0;
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      if (mem_rd) begin
        off = cyc - c0;
        check("mem_rd_in_issue_slot", (busy && off >= 0 && off <= 3) ? 1 : 0, 1);
        if (off >= 0 && off <= 3) begin
          got_rv[off] = 1'b1;
          got_ra[off] = mem_addr;
        end
      end
      if (cur_fl != prev_flags) check("flags_change_only_on_valid", int'(flags_valid), 1);
      prev_flags = cur_fl;
      if (flags_valid) begin
        probes_seen++;
        check("latency", cyc - c0, 5);
        check("busy_cycles", busy_cnt, 5);
        check("busy_low_at_valid", int'(busy), 0);
        if (sb_q.size() == 0) begin
          check("unexpected_flags_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          for (int d = 0; d < 4; d++) begin
            check($sformatf("flag_%s", dn[d]), int'(cur_fl[d]), int'(e.fl[d]));
            check($sformatf("read_addr_%s", dn[d]),
                  got_rv[d] ? int'(got_ra[d]) : -1, e.rv[d] ? int'(e.ra[d]) : -1);
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_probe();
    int start;
    bit got;
    start = probes_seen;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50mhz);
      if (probes_seen > start) begin
        got = 1'b1;
        break;
      end
    end
    check("probe_completes", int'(got), 1);
  endtask

  task automatic do_probe(input int nx, input int ny, input bit rf);
    @(negedge clk_50mhz);
    if (nx == cur_x && ny == cur_y) rf = 1'b1;
    x       = 9'(nx);
    y       = 9'(ny);
    cur_x   = nx;
    cur_y   = ny;
    refresh = rf;
    sb_q.push_back(model(nx, ny));
    @(negedge clk_50mhz);
    refresh = 1'b0;
    wait_probe();
  endtask

  function automatic int pick();
    int b[6] = '{0, 8, 240, 248, 256, 504};
    case ($urandom_range(0, 3))
      0:       return 8 * int'($urandom_range(0, 63));
      1:       return int'($urandom_range(0, 511));
      2:       return b[$urandom_range(0, 5)];
      default: return 8 * int'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    x       = 9'd200;
    y       = 9'd232;
    refresh = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = 3'd1;
    #3;
    check("reset_flags", int'({flag_D, flag_R, flag_U, flag_L}), 0);
    check("reset_flags_valid", int'(flags_valid), 0);
    check("reset_mem_rd", int'(mem_rd), 0);
    check("reset_mem_addr", int'(mem_addr), 0);
    check("reset_busy", int'(busy), 0);

    // First probe starts right after release (reads 952, 921, 954, 985).
    sb_q.push_back(model(200, 232));
    @(negedge clk_50mhz);
    #3 rst_n = 1'b1;
    wait_probe();

    // Misaligned y: only U and D are read.
    do_probe(200, 234, 1'b0);

    // Left edge underflow, then right neighbour off the map.
    do_probe(0, 8, 1'b0);
    mem[63] = 3'd1;
    do_probe(248, 8, 1'b0);

    // Wall above, pellet below.
    mem[921] = 3'd0;
    mem[985] = 3'd2;
    do_probe(200, 232, 1'b0);

    // x moves during ISS_R: old position completes, then a reprobe at x=201.
    @(negedge clk_50mhz);
    x = 9'd200; y = 9'd232; refresh = 1'b1;
    sb_q.push_back(model(200, 232));
    @(negedge clk_50mhz);
    refresh = 1'b0;
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
    x = 9'd201;
    cur_x = 201;
    sb_q.push_back(model(201, 232));
    wait_probe();
    wait_probe();

    // Map change picked up through refresh at an unchanged position.
    do_probe(200, 232, 1'b0);
    mem[952] = 3'd0;
    do_probe(200, 232, 1'b1);

    // Reset during ISS_U aborts the probe; a fresh one follows release.
    @(negedge clk_50mhz);
    refresh = 1'b1;
    sb_q.push_back(model(cur_x, cur_y));
    @(negedge clk_50mhz);
    refresh = 1'b0;
    @(negedge clk_50mhz);
    #3 rst_n = 1'b0;
    #1;
    check("abort_flags", int'({flag_D, flag_R, flag_U, flag_L}), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_mem_rd", int'(mem_rd), 0);
    sb_q.delete();
    sb_q.push_back(model(cur_x, cur_y));
    @(negedge clk_50mhz);
    #3 rst_n = 1'b1;
    wait_probe();

    // Randomized positions over a randomized map.
    for (int a = 0; a < 1024; a++) mem[a] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) mem[$urandom_range(0, 1023)] = 3'($urandom_range(0, 7));
      do_probe(pick(), pick(), $urandom_range(0, 3) == 0);
    end

    repeat (5) @(negedge clk_50mhz);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_probe.md
Name: maze_probe

Overview:
Map-side responder for the pacman movement logic. It takes the sprite position (x, y) and returns the four per-direction passability flags (flag_L/U/R/D) that the movement logic uses to accept turns and advance.
It reads the neighbouring tiles from a synchronous tile-map ROM/RAM, one read per direction, in a fixed sequence. All four flags are then updated in the same cycle.
It sits between the pacman mover (and any ghost mover) and the maze tile memory.

Parameters:
COORD_W, 9, pixel coordinate width
TILE_BITS, 3, log2 of tile edge in pixels (8 px tiles)
MAP_W_BITS, 5, log2 of map width in tiles (32)
MAP_H_BITS, 5, log2 of map height in tiles (32)
DATA_W, 3, tile code width (0 = wall, nonzero = passable class)

Ports:
clk_50mhz  in  1  system clock
rst_n  in  1  asynchronous active-low reset
x  in  COORD_W  sprite top-left x, pixels
y  in  COORD_W  sprite top-left y, pixels
refresh  in  1  force re-probe at the same position (map contents changed)
mem_addr  out  MAP_W_BITS+MAP_H_BITS  tile address = {tile_y, tile_x}
mem_rd  out  1  read strobe; data is valid on mem_data exactly 1 cycle later
mem_data  in  DATA_W  tile code returned by memory
flag_L  out  DATA_W  code of the tile to the left; 0 = blocked
flag_U  out  DATA_W  code of the tile above; 0 = blocked
flag_R  out  DATA_W  code of the tile to the right; 0 = blocked
flag_D  out  DATA_W  code of the tile below; 0 = blocked
flags_valid  out  1  one-cycle pulse when the flags update
busy  out  1  high while a probe is in progress

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all flags 0, flags_valid 0, mem_rd 0, mem_addr 0, busy 0.
  - state IDLE, internal stale bit = 1, so the first probe starts on the first edge after release.
- States: IDLE -> ISS_L -> ISS_U -> ISS_R -> ISS_D -> LAST -> IDLE.
- IDLE exit condition: stale=1, or refresh=1, or (x,y) differs from the last probed position.
  - On exit: capture x,y into px,py; busy=1; clear stale.
  - refresh is level-sampled only in IDLE; a refresh pulse during a probe sets stale.
- Probe pixels, with T = 1<<TILE_BITS:
  - L: (px-1, py), requires py tile-aligned.
  - U: (px, py-1), requires px tile-aligned.
  - R: (px+T, py), requires py tile-aligned.
  - D: (px, py+T), requires px tile-aligned.
  - Pixel arithmetic is 1 bit wider than COORD_W. Tile index = pixel >> TILE_BITS.
- Invalid probe: misaligned, underflow (px=0 for L, py=0 for U), or tile index >= map size.
  - In that ISS cycle mem_rd=0 and mem_addr holds its previous value.
  - The corresponding result is forced to 0.
- Valid probe: mem_rd=1 and mem_addr={tile_y,tile_x} during the ISS cycle.
- Result capture: mem_data is captured into a shadow register on the following cycle.
  - L is captured in ISS_U, U in ISS_R, R in ISS_D, D in LAST.
- At the edge leaving LAST:
  - all four flags load from the shadow registers simultaneously.
  - flags_valid=1 for exactly one cycle; busy falls.
- Latency: IDLE exit edge to flags update = 5 cycles. Back-to-back probes are separated by at least 1 IDLE cycle.
- Flags hold their old values during a probe; no partial update is ever visible.
- x,y changes mid-probe are ignored for the current probe. The next IDLE cycle detects the mismatch and reprobes.
- Reset mid-probe aborts immediately. Outputs go to reset values and the shadow registers are discarded.

Test Plan:
1. Reset release, x=200, y=232; memory all 1.
   -> mem_rd addresses 952, 921, 954, 985 on 4 consecutive cycles; all flags=1 and flags_valid pulses 5 cycles after the start; busy high for 5 cycles.
2. x=200, y=234 (y misaligned).
   -> no mem_rd in the L and R slots; U addr 953, D addr 985; flag_L=flag_R=0.
3. x=0, y=8; then x=248, y=8 with tile (31,1)=1.
   -> flag_L=0 with no read at x=0; at x=248, flag_R=0 (tile 32 out of range) with no read.
4. Wall at addr 921 (code 0), pellet code 2 at 985.
   -> flag_U=0, flag_D=2; flags change only on the flags_valid cycle.
5. x changes 200->201 during ISS_R.
   -> first probe completes using x=200, then a second probe starts; final flag_U=flag_D=0 (misaligned).
6. refresh=1 at an unchanged position after memory addr 952 is changed to 0 -> new probe with flag_L=0.
   Separately: rst_n=0 during ISS_U -> flags=0, busy=0, and a probe restarts after release.
